// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter: camera write stream plus readout read channel.
interface sram_port_arbiter_if #(
  parameter int unsigned AW = 20
);
  logic          i_wr_req;
  logic [AW-1:0] i_wr_addr;
  logic [15:0]   i_wr_data;
  logic          o_wr_full;
  logic [15:0]   o_drop_cnt;
  logic          i_rd_req;
  logic [AW-1:0] i_rd_addr;
  logic          o_rd_ack;
  logic          o_rd_valid;
  logic [15:0]   o_rd_data;
  logic          o_idle;

  modport master (
    output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
    input  o_wr_full, o_drop_cnt, o_rd_ack, o_rd_valid, o_rd_data, o_idle
  );

  modport slave (
    input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
    output o_wr_full, o_drop_cnt, o_rd_ack, o_rd_valid, o_rd_data, o_idle
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one async 16-bit SRAM between a non-stallable camera write stream (buffered in a
// small FIFO) and a stallable readout path; writes win unless a read has starved too long.
module sram_port_arbiter #(
  parameter int unsigned WFIFO_DEPTH  = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned AW           = 20
) (
  input  logic               i_vga_clk,
  input  logic               i_rst,
  sram_port_arbiter_if.slave bus,
  output logic [AW-1:0]      SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_UB_N
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(WFIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_WRITE = 2'd1,
    GNT_READ  = 2'd2
  } grant_e;

  wr_entry_t         fifo_q [WFIFO_DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [15:0]       drop_q, drop_d;
  logic [AW-1:0]     sram_addr_q, sram_addr_d;
  logic              we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [DW-1:0]     dq_out_q, dq_out_d;
  logic              rd_p1_q, rd_p1_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;

  grant_e            grant_c;
  logic              full_c, empty_c, starved_c, push_c, pop_c;
  wr_entry_t         head_c;

  // Grant selection, FIFO bookkeeping and next SRAM cycle, all from registered state.
  always_comb begin
    full_c      = (cnt_q == CW'(WFIFO_DEPTH));
    empty_c     = (cnt_q == '0);
    starved_c   = (starve_q == SW'(STARVE_LIMIT));
    head_c      = fifo_q[rptr_q];
    grant_c     = GNT_NONE;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    drop_d      = drop_q;
    sram_addr_d = sram_addr_q;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b0;
    dq_oe_d     = 1'b0;
    dq_out_d    = dq_out_q;
    rd_p1_d     = 1'b0;
    rd_valid_d  = rd_p1_q;
    rd_data_d   = rd_data_q;

    if (full_c)                          grant_c = GNT_WRITE;
    else if (bus.i_rd_req && starved_c)  grant_c = GNT_READ;
    else if (!empty_c)                   grant_c = GNT_WRITE;
    else if (bus.i_rd_req)               grant_c = GNT_READ;

    // Full is taken from the registered count, so a push coinciding with the full-pop is lost.
    push_c = bus.i_wr_req && !full_c;
    pop_c  = (grant_c == GNT_WRITE);

    if (push_c) wptr_d = wptr_q + PW'(1);
    if (pop_c)  rptr_d = rptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push_c) - CW'(pop_c);

    if (bus.i_wr_req && full_c && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

    if (!bus.i_rd_req || (grant_c == GNT_READ)) starve_d = '0;
    else if (!starved_c)                        starve_d = starve_q + SW'(1);

    unique case (grant_c)
      GNT_WRITE: begin
        sram_addr_d = head_c.addr;
        we_n_d      = 1'b0;
        oe_n_d      = 1'b1;
        dq_oe_d     = 1'b1;
        dq_out_d    = head_c.data;
      end
      GNT_READ: begin
        sram_addr_d = bus.i_rd_addr;
        rd_p1_d     = 1'b1;
      end
      default: ;
    endcase

    // The read cycle's DQ is sampled at the edge that closes it.
    if (rd_p1_q) rd_data_d = SRAM_DQ;
  end

  always_ff @(posedge i_vga_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      drop_q      <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b0;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
      rd_p1_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      drop_q      <= drop_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
      rd_p1_q     <= rd_p1_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge i_vga_clk) begin
    if (push_c) fifo_q[wptr_q] <= '{addr: bus.i_wr_addr, data: bus.i_wr_data};
  end

  assign bus.o_wr_full  = full_c;
  assign bus.o_drop_cnt = drop_q;
  assign bus.o_rd_ack   = (grant_c == GNT_READ) && !i_rst;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_idle     = empty_c && !rd_p1_q && !rd_valid_q;

  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {DW{1'bz}};
  assign SRAM_CE_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_UB_N = 1'b0;

endmodule
